mine_placer: RTL and testbench
==============================

# mine_placer

Synthesizable mine-placement engine for the 8x8 Buscaminas board. On a start request it clears an internal 8x8 grid and places `cant_minas` mines at pseudo-random, non-repeating positions drawn from a free-running 16-bit LFSR. It sits directly upstream of the mine-grid register, which captures `grid_minas` while `grid_valid` is high. It replaces simulation-only `$random` placement with hardware that yields a new board per game.

## Interface
- `LFSR_SEED`, 16'hACE1: LFSR value after reset; must be non-zero.
- `LFSR_TAPS`, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: request a new board; sampled only in IDLE.
- `cant_minas`  in  4: number of mines, 0..15; latched when start is accepted.
- `seed_load`  in  1: load `seed` into the LFSR this edge.
- `seed`  in  16: seed value; 16'h0000 is replaced by `LFSR_SEED`.
- `grid_minas`  out  [1:0] [0:7][0:7]: board; 2'b00 neutral, 2'b11 mine; no other codes are produced.
- `busy`  out  1: high from CLEAR through DONE.
- `done`  out  1: one-cycle pulse when placement completes.
- `grid_valid`  out  1: level; board complete and stable.

## Operation
- LFSR: 16-bit Galois, right shift. Next value = `lfsr>>1`, XORed with `LFSR_TAPS` when `lfsr[0]`=1. It advances on every clock edge in every state. `seed_load` overrides the advance that edge. The LFSR never holds zero.
- Coordinates for a placement attempt come from the current registered LFSR: row = `lfsr[5:3]`, col = `lfsr[2:0]`.
- FSM states: IDLE, CLEAR, PLACE, DONE.
  - IDLE: on `start`=1, latch `cant_minas` into `target` and go to CLEAR. Otherwise stay.
  - CLEAR: write all 64 cells to 2'b00 and set `placed`=0. Go to DONE if `target`=0, else to PLACE.
  - PLACE: read cell[row][col].
    - If it is 2'b00, write 2'b11 and increment `placed` (5-bit counter). If `placed`+1 = `target`, go to DONE.
    - If the cell already holds a mine, write nothing, increment nothing, and retry next cycle.
  - DONE: `done`=1 for this cycle only, then go to IDLE.
- `grid_valid` sets on entry to DONE. It clears on entry to CLEAR and stays low through CLEAR/PLACE.
- `start` while `busy` is ignored and is not queued. `cant_minas` changes after acceptance have no effect.
- Termination: the maximal-length LFSR visits every 6-bit coordinate within its period. With at most 15 mines there are always free cells, so PLACE always terminates.
- Mine count invariant: in DONE, exactly `target` cells equal 2'b11.

## Timing
- Reset values:
  - `grid_minas` all 2'b00
  - `busy`=0, `done`=0, `grid_valid`=0
  - state IDLE
  - `lfsr`=`LFSR_SEED`
  - `target`=0, `placed`=0
- Start sampled at edge E0:
  - E1: state CLEAR; `busy`=1; `grid_valid`=0.
  - E2: grid all 00; state PLACE (or DONE if `target`=0).
  - Each PLACE cycle commits at most one mine.
  - With no collisions and `target`=k>0: the last mine is written at E(2+k). `done`=1 and `grid_valid`=1 during the cycle after E(2+k). At E(3+k), `busy`=0 and `done`=0.
  - `target`=0: `done` is high after E2; `busy` drops at E3.
- Each collision adds exactly one cycle.
- `grid_minas` is registered. It never shows a partial board while `grid_valid`=1.
- `seed_load` in any state takes effect at that edge and does not disturb the FSM.
- Reset mid-operation (any state): all outputs and state return to reset values asynchronously. No `done` pulse is produced. A new `start` is needed.
- `start` held high continuously: after each DONE→IDLE, the next edge accepts it again. A new board follows every run.

## Test plan
- Reset values: assert `reset` mid-PLACE with 7 mines committed. Required: all 64 cells 00 immediately; `busy`/`done`/`grid_valid`=0; `lfsr`=16'hACE1 after release.
- Zero mines: `start` with `cant_minas`=0. Required: `busy` high for E1-E2, `done` pulse after E2, all cells 00, `grid_valid`=1.
- Deterministic placement: `seed_load` with `seed`=16'h0001, then `start` with `cant_minas`=15. Required: cell-for-cell match with a bench LFSR model, 15 cells 11 and 49 cells 00, `done` width exactly 1 cycle. `busy` duration = 17 + collision count cycles.
- Collision retry: choose a seed whose LFSR sequence repeats a coordinate within the first 4 attempts, with `cant_minas`=4. Required: the repeated attempt writes nothing and `done` arrives one cycle later than the no-collision case.
- Busy/start interaction: pulse `start` with `cant_minas`=3 during PLACE of a 10-mine run. Required: ignored; the final board has 10 mines; `grid_valid` stays high in IDLE until the next accepted `start`.
- Zero seed: `seed_load` with `seed`=16'h0000. Required: `lfsr`=16'hACE1 next cycle and never zero afterwards.

Source files
------------

// File: rtl/mine_placer_if.sv
`default_nettype none
// ============================================================================
// Module      : mine_placer_if
// Description : Control/status and board bundle between the mine placer and
//               its user (game controller / mine-grid register).
// Revision    : 1.0 - initial release
// ============================================================================
interface mine_placer_if;
    logic                   start;
    logic [3:0]             cant_minas;
    logic                   seed_load;
    logic [15:0]            seed;
    logic [0:7][0:7][1:0]   grid_minas;
    logic                   busy;
    logic                   done;
    logic                   grid_valid;

    modport master (
        output start, cant_minas, seed_load, seed,
        input  grid_minas, busy, done, grid_valid
    );

    modport slave (
        input  start, cant_minas, seed_load, seed,
        output grid_minas, busy, done, grid_valid
    );
endinterface
`default_nettype wire

// File: rtl/mine_placer.sv
`default_nettype none
// ============================================================================
// Module      : mine_placer
// Description : Places up to 15 mines on an 8x8 board at non-repeating
//               positions drawn from a free-running 16-bit Galois LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module mine_placer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [15:0] LFSR_TAPS = 16'hB400
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mine_placer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PLACE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q,      state_d;
    logic [15:0]            lfsr_q,       lfsr_d;
    logic [3:0]             target_q,     target_d;
    logic [4:0]             placed_q,     placed_d;
    logic [0:7][0:7][1:0]   grid_q,       grid_d;
    logic                   grid_valid_q, grid_valid_d;

    logic [15:0]            w_lfsr_step;
    logic [2:0]             w_row;
    logic [2:0]             w_col;
    logic [4:0]             w_placed_inc;

    assign w_lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign w_row        = lfsr_q[5:3];
    assign w_col        = lfsr_q[2:0];
    assign w_placed_inc = placed_q + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            target_q     <= 4'd0;
            placed_q     <= 5'd0;
            grid_q       <= '0;
            grid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            target_q     <= target_d;
            placed_q     <= placed_d;
            grid_q       <= grid_d;
            grid_valid_q <= grid_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        placed_d     = placed_q;
        grid_d       = grid_q;
        grid_valid_d = grid_valid_q;

        // A zero seed would lock the LFSR, so it falls back to the reset seed.
        if (bus.seed_load) begin
            lfsr_d = (bus.seed == 16'h0000) ? LFSR_SEED : bus.seed;
        end else begin
            lfsr_d = w_lfsr_step;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    target_d     = bus.cant_minas;
                    grid_valid_d = 1'b0;
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                grid_d   = '0;
                placed_d = 5'd0;
                if (target_q == 4'd0) begin
                    grid_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                // An occupied cell is simply retried with the next LFSR value.
                if (grid_q[w_row][w_col] == 2'b00) begin
                    grid_d[w_row][w_col] = 2'b11;
                    placed_d             = w_placed_inc;
                    if (w_placed_inc == {1'b0, target_q}) begin
                        grid_valid_d = 1'b1;
                        state_d      = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.grid_minas = grid_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.grid_valid = grid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mine_placer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mine_placer
// Description : Self-checking bench for mine_placer against a board-level
//               placement model driven by a reference LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mine_placer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] m_lfsr;

    mine_placer_if bus ();

    mine_placer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference LFSR: tracks what the engine's generator must hold each cycle.
    always @(posedge clk or posedge reset) begin
        if (reset)              m_lfsr <= 16'hACE1;
        else if (bus.seed_load) m_lfsr <= (bus.seed == 16'h0000) ? 16'hACE1 : bus.seed;
        else                    m_lfsr <= lstep(m_lfsr);
    end

    // Board expected from a start accepted while the generator holds l0.
    function automatic int predict(input logic [15:0] l0, input int k, output logic [127:0] g);
        logic [0:7][0:7][1:0] b;
        logic [15:0] l;
        int placed;
        int att;
        b = '0;
        l = lstep(lstep(l0));
        placed = 0;
        att = 0;
        while (placed < k) begin
            att++;
            if (b[l[5:3]][l[2:0]] == 2'b00) begin
                b[l[5:3]][l[2:0]] = 2'b11;
                placed++;
            end
            l = lstep(l);
        end
        g = b;
        return att;
    endfunction

    function automatic int count_mines(input logic [127:0] g);
        int n = 0;
        for (int i = 0; i < 64; i++) if (g[2*i +: 2] == 2'b11) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_seed(input logic [15:0] s);
        bus.seed_load = 1'b1;
        bus.seed      = s;
        @(negedge clk);
        bus.seed_load = 1'b0;
    endtask

    // Runs one board from the current negedge; optionally pokes start mid-run.
    task automatic do_run(input int k, input int poke, input string tag, output int bc);
        logic [127:0] eg;
        int att;
        int dc;
        int guard;
        att = predict(m_lfsr, k, eg);
        bus.start      = 1'b1;
        bus.cant_minas = k[3:0];
        @(negedge clk);
        bus.start      = 1'b0;
        bus.cant_minas = 4'($urandom_range(0, 15));
        check({tag, "_busy_e1"}, 128'(bus.busy), 128'(1));
        check({tag, "_gv_e1"},   128'(bus.grid_valid), 128'(0));
        bc = 0;
        dc = 0;
        guard = 0;
        while (bus.busy && guard < 300) begin
            bc++;
            if (bus.done) begin
                dc++;
                check({tag, "_board"}, bus.grid_minas, eg);
                check({tag, "_mines"}, 128'(count_mines(bus.grid_minas)), 128'(k));
                check({tag, "_gv_done"}, 128'(bus.grid_valid), 128'(1));
            end
            bus.start      = (bc == poke);
            bus.cant_minas = 4'd3;
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        check({tag, "_busy_cycles"}, 128'(bc), 128'(att + 2));
        check({tag, "_done_width"}, 128'(dc), 128'(1));
        check({tag, "_done_low"}, 128'(bus.done), 128'(0));
    endtask

    initial begin
        int bc_a;
        int bc_b;
        int att;
        int guard;
        logic [127:0] eg;
        logic [127:0] held;
        logic [15:0] s_col;
        logic [15:0] s_ok;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.cant_minas = 4'd0;
        bus.seed_load  = 1'b0;
        bus.seed       = 16'h0000;
        #1;
        check("rst_grid", bus.grid_minas, 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_gv",   128'(bus.grid_valid), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_lfsr", 128'(dut.lfsr_q), 128'(16'hACE1));
        @(negedge clk);

        // Zero mines: CLEAR straight into DONE.
        do_run(0, -1, "zero", bc_a);

        // Deterministic board from seed 1 with the maximum mine count.
        load_seed(16'h0001);
        check("seed1_lfsr", 128'(dut.lfsr_q), 128'(16'h0001));
        do_run(15, -1, "det15", bc_a);

        // Find one seed with a single early collision and one with none.
        s_col = 16'h0000;
        s_ok  = 16'h0000;
        for (int s = 1; s < 65536; s++) begin
            att = predict(16'(s), 4, eg);
            if (att == 5 && s_col == 16'h0000) s_col = 16'(s);
            if (att == 4 && s_ok  == 16'h0000) s_ok  = 16'(s);
            if (s_col != 16'h0000 && s_ok != 16'h0000) break;
        end
        load_seed(s_ok);
        do_run(4, -1, "nocol", bc_a);
        load_seed(s_col);
        do_run(4, -1, "col", bc_b);
        check("col_extra_cycle", 128'(bc_b), 128'(bc_a + 1));

        // Start during PLACE is ignored; finished board stays valid in IDLE.
        do_run(10, 4, "ignore", bc_a);
        held = bus.grid_minas;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_gv", 128'(bus.grid_valid), 128'(1));
            check("idle_board", bus.grid_minas, held);
        end
        do_run(2, -1, "after_idle", bc_a);

        // Zero seed falls back to the reset seed and never locks up.
        load_seed(16'h0000);
        check("zseed_lfsr", 128'(dut.lfsr_q), 128'(16'hACE1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("zseed_model", 128'(dut.lfsr_q), 128'(m_lfsr));
            check("zseed_nonzero", 128'(dut.lfsr_q != 16'h0000), 128'(1));
        end

        // Randomized seeds and mine counts.
        for (int r = 0; r < 6; r++) begin
            load_seed(16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(int'($urandom_range(0, 15)), -1, "rand", bc_a);
        end

        // Asynchronous reset in the middle of a 15-mine placement.
        load_seed(16'($urandom));
        bus.start      = 1'b1;
        bus.cant_minas = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (count_mines(bus.grid_minas) < 7 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reach7", 128'(count_mines(bus.grid_minas)), 128'(7));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_grid", bus.grid_minas, 128'(0));
        check("mid_rst_busy", 128'(bus.busy), 128'(0));
        check("mid_rst_done", 128'(bus.done), 128'(0));
        check("mid_rst_gv",   128'(bus.grid_valid), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_lfsr", 128'(dut.lfsr_q), 128'(16'hACE1));
        @(negedge clk);
        check("mid_rst_idle", 128'(bus.busy), 128'(0));
        do_run(5, -1, "post_rst", bc_a);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
